barrel_shift_pipe: RTL

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_stage.sv | 55 +++++
 rtl/barrel_shift_pipe.sv | 62 ++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op codes and the
// control bundle that travels alongside the data through every stage.
package shift_pkg;

  localparam logic [2:0] OP_ROR = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  typedef struct packed {
    logic       valid;
    logic [2:0] op;
    logic       fill;
  } stage_bundle_t;

  function automatic logic op_reserved(input logic [2:0] code);
    return code > OP_SRA;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered barrel-shifter stage: shifts by DIST when the matching
// shamt bit is set, then clears that bit in the shamt it passes on.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1,
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  stage_bundle_t   in_ctrl,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]   in_shamt,
  output stage_bundle_t   out_ctrl,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]   out_shamt
);

  localparam int BIT = $clog2(DIST);
  localparam logic [SW-1:0] KEEP = ~(SW'(1) << BIT);

  logic [WIDTH-1:0] fill_mask;
  logic [WIDTH-1:0] shifted;

  assign fill_mask = {WIDTH{in_ctrl.fill}} << (WIDTH - DIST);

  always_comb begin
    shifted = in_data;
    if (in_shamt[BIT]) begin
      case (in_ctrl.op)
        OP_ROR:  shifted = (in_data >> DIST) | (in_data << (WIDTH - DIST));
        OP_ROL:  shifted = (in_data << DIST) | (in_data >> (WIDTH - DIST));
        OP_SRL:  shifted = in_data >> DIST;
        OP_SLL:  shifted = in_data << DIST;
        OP_SRA:  shifted = (in_data >> DIST) | fill_mask;
        default: shifted = in_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_ctrl  <= '0;
      out_data  <= '0;
      out_shamt <= '0;
    end else if (advance) begin
      out_ctrl  <= in_ctrl;
      out_data  <= shifted;
      out_shamt <= in_shamt & KEEP;
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: SW registered stages, largest distance first,
// with a single global stall driven by the output handshake.
module barrel_shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SW-1:0]    shamt,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_zero,
  output logic             out_err
);

  logic             advance;
  stage_bundle_t    ctrl [SW+1];
  logic [WIDTH-1:0] data [SW+1];
  logic [SW-1:0]    amt  [SW+1];
  logic             unused_tail;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign ctrl[0] = stage_bundle_t'{valid: in_valid, op: op, fill: din[WIDTH-1]};
  assign data[0] = din;
  assign amt[0]  = shamt;

  for (genvar i = 0; i < SW; i++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << (SW - 1 - i))
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (advance),
      .in_ctrl   (ctrl[i]),
      .in_data   (data[i]),
      .in_shamt  (amt[i]),
      .out_ctrl  (ctrl[i+1]),
      .out_data  (data[i+1]),
      .out_shamt (amt[i+1])
    );
  end

  assign out_valid = ctrl[SW].valid;
  assign dout      = data[SW];
  // Bubbles may carry a stale op, so err and zero are qualified by valid.
  assign out_err   = out_valid && op_reserved(ctrl[SW].op);
  assign out_zero  = out_valid && (dout == '0);

  // The final stage's fill bit and spent shamt have no consumer.
  assign unused_tail = ^{ctrl[SW].fill, amt[SW]};

endmodule
